viterbi_codec: RTL and testbench
================================

Name: viterbi_codec

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder plus hard-decision 4-state Viterbi decoder, packaged as one codec block.
- The encoder path and the decoder path are independent.
- In the system, encoder output travels through an external noisy channel: registered, possibly bit-flipped, re-timed with the decoder enable. It then returns to the decoder input.
- With a clean channel, the decoder output reproduces the encoder input stream after a fixed latency.

Parameters:
- TB_LEN, 24, survivor (register-exchange) depth in symbols; must be ≥ 2 and ≤ 64.
- PM_W, 8, path-metric width in bits.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enc_enable_i  input  1  encoder input bit valid this cycle.
- enc_d_i  input  1  encoder data bit.
- enc_valid_o  output  1  registered: enc_d_o valid.
- enc_d_o  output  2  registered code symbol {g1 bit, g0 bit}.
- dec_enable_i  input  1  decoder symbol valid this cycle.
- dec_d_i  input  2  received hard-decision symbol {bit1, bit0}.
- dec_d_o  output  1  decoded bit, registered.

Behaviour:
- Encoder:
  - Shift register sr[1:0]: sr[1] holds the newest previous bit, sr[0] the older one.
  - Generators: g1 = 111 (octal 7) and g0 = 101 (octal 5).
  - On a clock edge with enc_enable_i=1:
    - enc_d_o <= {d^sr[1]^sr[0], d^sr[0]}, where d = enc_d_i.
    - sr <= {d, sr[1]}.
    - enc_valid_o <= 1.
  - On a clock edge with enc_enable_i=0: sr holds, enc_d_o <= 2'b00, enc_valid_o <= 0.
  - Latency is 1 cycle.
  - Reset: sr=0, enc_d_o=0, enc_valid_o=0.
- Decoder trellis:
  - State s = last two inputs, {newest, older}.
  - From predecessor p, input b leads to state {b, p[1]}.
  - State s has two predecessors: {s[0],0} and {s[0],1}.
  - Expected symbol for a transition is the encoder formula applied with d=b and sr=p.
- Branch metric:
  - Hamming distance between dec_d_i and the expected symbol, in the range 0..2.
- ACS, every cycle with dec_enable_i=1:
  - For each state, compute candidate = PM[p] + BM for both predecessors.
  - Pick the smaller candidate; on a tie, pick the predecessor with p[0]=0.
  - Then subtract the minimum of the four new metrics from all four (normalisation).
  - Saturate at 2^PM_W−1.
- Survivor handling (register-exchange):
  - surv_new[s] = {surv[p_sel][TB_LEN-2:0], s[1]}.
  - Bit 0 is the newest decision.
- Output:
  - dec_d_o <= surv_new[best][TB_LEN-1], where best is the state with minimum new metric; ties go to the lowest index.
- dec_enable_i=0: all metrics, survivors and dec_d_o hold.
- Latency: the bit carried by the symbol sampled at enabled edge k appears on dec_d_o right after enabled edge k+TB_LEN−1.
- Reset:
  - PM[0]=0, PM[1..3]=16 (the encoder starts in state 0).
  - surv=0 and dec_d_o=0.
- Reset mid-stream: both paths return to reset values immediately; no partial output is flushed.
- Error tolerance: any pattern of ≤2 flipped channel bits within any 5·3=15-symbol window must decode error-free.

Decomposition:
- Package viterbi_pkg:
  - K=3, NSTATES=4.
  - G1=3'b111, G0=3'b101.
  - A function exp_sym(b, p) returning the 2-bit expected symbol, shared by the encoder and the branch-metric unit.
- Sub-module conv_encoder holds the encoder.
- The decoder (BMC, ACS, register-exchange) stays in the top module body.

Test Plan:
- Reset asserted mid-run: enc_valid_o=0, enc_d_o=00, dec_d_o=0 asynchronously.
- Decoder state after that reset: metrics equal {0,16,16,16}.
- Encoder impulse (1 then zeros, enable high) -> enc_d_o sequence 11, 10, 11, 00, 00…
- Encoder all-ones -> enc_d_o sequence 11, 01, 10, 10, 10…
- Enable gap: enc_enable_i low for 3 cycles mid-stream -> enc_d_o=00 and enc_valid_o=0 for those cycles; codeword continuity resumes, since sr held.
- Clean loopback: random 300-bit stream through encoder -> 1-cycle channel register -> decoder (enable = delayed enc_valid_o). dec_d_o must equal the input stream delayed by TB_LEN−1 enabled cycles, after that fill period.
- Burst-error loopback: flip bit[1] of 4 consecutive symbols every 32 symbols for the first 256 symbols. Then flip a single random bit per 16 symbols. Decoded stream must match the input except where the burst exceeds 2 errors per 15-symbol window, and must be error-free in the single-error phase.

Source files
------------

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and code-symbol function for the Viterbi codec
package viterbi_pkg;

    localparam int K       = 3;
    localparam int NSTATES = 4;

    // Generator taps applied to {d, sr[1], sr[0]}.
    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G0 = 3'b101;

    // Non-zero start metric for states the encoder cannot be in after reset.
    localparam int PM_INIT = 16;

    typedef logic [1:0] sym_t;

    // Code symbol {g1, g0} emitted when bit b enters an encoder holding p = {newer, older}.
    function automatic sym_t exp_sym(input logic b, input logic [1:0] p);
        logic [K-1:0] w_taps;
        w_taps = {b, p};
        return {^(w_taps & G1), ^(w_taps & G0)};
    endfunction

endpackage

// File: rtl/viterbi_codec_if.sv
// rtl/viterbi_codec_if.sv - encoder and decoder stream signals of the codec
interface viterbi_codec_if;
    import viterbi_pkg::*;

    logic enc_enable_i;
    logic enc_d_i;
    logic enc_valid_o;
    sym_t enc_d_o;
    logic dec_enable_i;
    sym_t dec_d_i;
    logic dec_d_o;

    modport slave (
        input  enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
        output enc_valid_o, enc_d_o, dec_d_o
    );

    modport master (
        output enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
        input  enc_valid_o, enc_d_o, dec_d_o
    );

endinterface

// File: rtl/viterbi_codec_conv_encoder.sv
// rtl/viterbi_codec_conv_encoder.sv - rate-1/2 K=3 convolutional encoder, one-cycle latency
module conv_encoder
    import viterbi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_d,
    output logic o_valid,
    output sym_t o_d
);

    logic [1:0] r_sr;
    logic       r_valid;
    sym_t       r_d;

    // Shift register advances only on enabled cycles; idle cycles emit a zero, invalid symbol.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr    <= 2'b00;
            r_d     <= 2'b00;
            r_valid <= 1'b0;
        end else if (i_enable) begin
            r_d     <= exp_sym(i_d, r_sr);
            r_sr    <= {i_d, r_sr[1]};
            r_valid <= 1'b1;
        end else begin
            r_d     <= 2'b00;
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_d     = r_d;

endmodule

// File: rtl/viterbi_codec.sv
// rtl/viterbi_codec.sv - convolutional encoder plus 4-state register-exchange Viterbi decoder
module viterbi_codec
    import viterbi_pkg::*;
#(
    parameter int TB_LEN = 24,
    parameter int PM_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    viterbi_codec_if.slave bus
);

    localparam logic [PM_W-1:0] PM_MAX = {PM_W{1'b1}};

    typedef struct packed {
        logic [PM_W-1:0] pm;
        logic [1:0]      prev;
    } acs_t;

    logic w_enc_valid;
    sym_t w_enc_d;

    conv_encoder u_enc (
        .clk      (clk),
        .rst      (rst),
        .i_enable (bus.enc_enable_i),
        .i_d      (bus.enc_d_i),
        .o_valid  (w_enc_valid),
        .o_d      (w_enc_d)
    );

    assign bus.enc_valid_o = w_enc_valid;
    assign bus.enc_d_o     = w_enc_d;

    logic [PM_W-1:0]   r_pm   [NSTATES];
    logic [TB_LEN-1:0] r_surv [NSTATES];
    logic              r_dec_d;

    acs_t              w_acs      [NSTATES];
    logic [PM_W-1:0]   w_pm_new   [NSTATES];
    logic [TB_LEN-1:0] w_surv_new [NSTATES];
    logic [PM_W-1:0]   w_pm_min;
    logic [1:0]        w_best;

    function automatic logic [1:0] hamming(input sym_t a, input sym_t b);
        sym_t w_x;
        w_x = a ^ b;
        return {1'b0, w_x[1]} + {1'b0, w_x[0]};
    endfunction

    // Metric plus branch cost, clamped so a runaway metric never wraps to a small value.
    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
        logic [PM_W:0] w_sum;
        w_sum = {1'b0, pm} + {{(PM_W-1){1'b0}}, bm};
        return w_sum[PM_W] ? PM_MAX : w_sum[PM_W-1:0];
    endfunction

    // Add-compare-select for one state; the even predecessor wins ties.
    function automatic acs_t acs(input logic [1:0] st, input sym_t rx,
                                 input logic [PM_W-1:0] pm_even, input logic [PM_W-1:0] pm_odd);
        logic [1:0]      w_p0;
        logic [1:0]      w_p1;
        logic [PM_W-1:0] w_c0;
        logic [PM_W-1:0] w_c1;
        acs_t            w_res;
        w_p0 = {st[0], 1'b0};
        w_p1 = {st[0], 1'b1};
        w_c0 = sat_add(pm_even, hamming(rx, exp_sym(st[1], w_p0)));
        w_c1 = sat_add(pm_odd,  hamming(rx, exp_sym(st[1], w_p1)));
        if (w_c1 < w_c0) begin
            w_res.pm   = w_c1;
            w_res.prev = w_p1;
        end else begin
            w_res.pm   = w_c0;
            w_res.prev = w_p0;
        end
        return w_res;
    endfunction

    // Survivor of the chosen predecessor, shifted up with the newest decision in bit 0.
    function automatic logic [TB_LEN-1:0] shift_in(input logic [TB_LEN-1:0] v, input logic b);
        return (v << 1) | TB_LEN'(b);
    endfunction

    // Branch metrics, ACS, survivor exchange, best-state search and metric normalisation.
    always_comb begin
        w_pm_min = '0;
        w_best   = 2'd0;
        for (int s = 0; s < NSTATES; s++) begin
            w_acs[s]      = acs(2'(s), bus.dec_d_i, r_pm[(s & 1) * 2], r_pm[(s & 1) * 2 + 1]);
            w_surv_new[s] = shift_in(r_surv[w_acs[s].prev], 1'((s >> 1) & 1));
        end
        w_pm_min = w_acs[0].pm;
        for (int s = 1; s < NSTATES; s++) begin
            if (w_acs[s].pm < w_pm_min) begin
                w_pm_min = w_acs[s].pm;
                w_best   = 2'(s);
            end
        end
        for (int s = 0; s < NSTATES; s++) begin
            w_pm_new[s] = w_acs[s].pm - w_pm_min;
        end
    end

    // Decoder state advances only on enabled symbols; reset pins the start to state 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NSTATES; s++) begin
                r_pm[s]   <= (s == 0) ? '0 : PM_W'(PM_INIT);
                r_surv[s] <= '0;
            end
            r_dec_d <= 1'b0;
        end else if (bus.dec_enable_i) begin
            for (int s = 0; s < NSTATES; s++) begin
                r_pm[s]   <= w_pm_new[s];
                r_surv[s] <= w_surv_new[s];
            end
            r_dec_d <= w_surv_new[w_best][TB_LEN-1];
        end
    end

    assign bus.dec_d_o = r_dec_d;

endmodule

// File: tb/tb_viterbi_codec.sv
// tb/tb_viterbi_codec.sv - scoreboard bench for the Viterbi codec
module tb_viterbi_codec;
    import viterbi_pkg::*;

    localparam int TB_LEN = 24;
    localparam int FL     = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    viterbi_codec_if bus ();

    viterbi_codec #(.TB_LEN(TB_LEN), .PM_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int         due;
        logic       v;
        logic [1:0] d;
    } enc_exp_t;

    typedef struct {
        logic b;
        logic chk;
    } dec_exp_t;

    enc_exp_t   enc_q[$];
    dec_exp_t   dec_q[$];
    logic       lb_en = 1'b0;
    logic [1:0] flips [FL];
    int         sym_idx   = 0;
    int         dec_edges = 0;
    int         dec_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Cycle counter used to schedule when encoder expectations fall due.
    always @(posedge clk) cyc <= cyc + 1;

    // Channel: one register stage between encoder output and decoder input, with planted bit flips.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.dec_enable_i <= 1'b0;
            bus.dec_d_i      <= 2'b00;
            sym_idx          <= 0;
            dec_edges        <= 0;
        end else begin
            if (bus.dec_enable_i) dec_edges <= dec_edges + 1;
            bus.dec_enable_i <= bus.enc_valid_o & lb_en;
            if (bus.enc_valid_o && lb_en) begin
                bus.dec_d_i <= bus.enc_d_o ^ ((sym_idx < FL) ? flips[sym_idx] : 2'b00);
                sym_idx     <= sym_idx + 1;
            end
        end
    end

    // Encoder monitor: compares each expectation on the cycle it falls due.
    always @(negedge clk) begin
        while (enc_q.size() > 0 && enc_q[0].due <= cyc) begin
            enc_exp_t e;
            e = enc_q.pop_front();
            if (e.due == cyc)
                check("enc_sym", {29'd0, bus.enc_valid_o, bus.enc_d_o}, {29'd0, e.v, e.d});
            else
                check("enc_late", 32'(cyc), 32'(e.due));
        end
    end

    // Decoder monitor: after the fill period every enabled edge releases one decoded bit.
    always @(negedge clk) begin
        if (!rst) begin
            dec_seen = 0;
        end else if (dec_edges != dec_seen) begin
            dec_seen = dec_edges;
            if (dec_edges >= TB_LEN) begin
                if (dec_q.size() == 0) begin
                    check("dec_underflow", 32'(dec_q.size()), 32'd1);
                end else begin
                    dec_exp_t d;
                    d = dec_q.pop_front();
                    if (d.chk) check("dec_bit", {31'd0, bus.dec_d_o}, {31'd0, d.b});
                end
            end
        end
    end

    task automatic do_reset(input bit chk_en, input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        if (chk_en) begin
            check({tag, "_enc_valid"}, {31'd0, bus.enc_valid_o}, 32'd0);
            check({tag, "_enc_d"},     {30'd0, bus.enc_d_o},     32'd0);
            check({tag, "_dec_d"},     {31'd0, bus.dec_d_o},     32'd0);
            for (int i = 0; i < NSTATES; i++)
                check({tag, "_pm"}, {24'd0, dut.r_pm[i]}, (i == 0) ? 32'd0 : 32'd16);
        end
        enc_q.delete();
        dec_q.delete();
        bus.enc_enable_i = 1'b0;
        bus.enc_d_i      = 1'b0;
        lb_en            = 1'b0;
        for (int i = 0; i < FL; i++) flips[i] = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic enc_step(input logic en, input logic d, input logic [1:0] exp_d);
        @(posedge clk);
        #1;
        bus.enc_enable_i = en;
        bus.enc_d_i      = d;
        enc_q.push_back('{cyc + 1, en, exp_d});
    endtask

    task automatic lb_bit(input logic d, input logic chk);
        @(posedge clk);
        #1;
        bus.enc_enable_i = 1'b1;
        bus.enc_d_i      = d;
        dec_q.push_back('{d, chk});
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        bus.enc_enable_i = 1'b0;
        bus.enc_d_i      = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Hand-computed encoder tables: {enable, data, expected {g1,g0}}.
    logic [3:0] t_impulse [5] = '{4'b1_1_11, 4'b1_0_10, 4'b1_0_11, 4'b1_0_00, 4'b1_0_00};
    logic [3:0] t_ones    [5] = '{4'b1_1_11, 4'b1_1_01, 4'b1_1_10, 4'b1_1_10, 4'b1_1_10};
    logic [3:0] t_gap     [9] = '{4'b1_1_11, 4'b1_1_01, 4'b0_0_00, 4'b0_1_00, 4'b0_0_00,
                                  4'b1_0_01, 4'b1_1_00, 4'b1_0_10, 4'b0_0_00};

    initial begin
        logic [3:0] v;
        bus.enc_enable_i = 1'b0;
        bus.enc_d_i      = 1'b0;
        for (int i = 0; i < FL; i++) flips[i] = 2'b00;

        do_reset(1'b1, "init");

        for (int i = 0; i < 5; i++) begin
            v = t_impulse[i];
            enc_step(v[3], v[2], v[1:0]);
        end
        idle(3);
        do_reset(1'b0, "r");

        for (int i = 0; i < 5; i++) begin
            v = t_ones[i];
            enc_step(v[3], v[2], v[1:0]);
        end
        idle(3);
        do_reset(1'b0, "r");

        for (int i = 0; i < 9; i++) begin
            v = t_gap[i];
            enc_step(v[3], v[2], v[1:0]);
        end
        idle(3);
        do_reset(1'b0, "r");

        lb_en = 1'b1;
        for (int i = 0; i < 300; i++) lb_bit(1'($urandom_range(0, 1)), 1'b1);
        for (int i = 0; i < TB_LEN; i++) lb_bit(1'b0, 1'b1);
        idle(TB_LEN + 4);
        do_reset(1'b0, "r");

        lb_en = 1'b1;
        for (int i = 0; i < 40; i++) lb_bit(1'b1, 1'b1);
        do_reset(1'b1, "midrun");

        for (int i = 0; i < 256; i++)
            if ((i % 32) < 4) flips[i] = 2'b10;
        for (int b = 0; b < 16; b++)
            flips[256 + 16 * b + int'($urandom_range(0, 15))] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        lb_en = 1'b1;
        for (int i = 0; i < 512; i++)
            lb_bit(1'($urandom_range(0, 1)), (i >= 256) || ((i % 32) >= 16 && (i % 32) <= 19));
        for (int i = 0; i < TB_LEN; i++) lb_bit(1'b0, 1'b1);
        idle(TB_LEN + 4);

        check("enc_q_drained", 32'(enc_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
